// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier.
// Holds the FSM state encoding used by shift_add_mult.
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_add.sv
// Parametrised carry-lookahead adder: o_s = i_a + i_b + i_ci (mod 2^W).
// Ports: i_a, i_b [W-1:0] addends; i_ci carry-in; o_s [W-1:0] sum.
module cla_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_ci,
  output logic [W-1:0] o_s
);

  logic [W-1:0] w_g;
  logic [W-1:0] w_p;
  logic [W-1:0] w_c;

  // Each carry is a flat sum-of-products of generate/propagate terms,
  // not a chain through the previous carry.
  always_comb begin
    logic t;
    w_g = i_a & i_b;
    w_p = i_a ^ i_b;
    w_c = '0;
    t   = 1'b0;
    for (int i = 0; i < W; i++) begin
      w_c[i] = 1'b0;
      for (int j = -1; j < i; j++) begin
        t = (j < 0) ? i_ci : w_g[j];
        for (int k = j + 1; k < i; k++) begin
          t = t & w_p[k];
        end
        w_c[i] = w_c[i] | t;
      end
    end
  end

  assign o_s = w_p ^ w_c;

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier, unsigned or signed operands.
// Ports: clk, rst (sync, active-low), start, sgn, A, B -> busy, done, Y.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WA = 4,
  parameter int WB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WA-1:0]    A,
  input  logic [WB-1:0]    B,
  output logic             busy,
  output logic             done,
  output logic [WA+WB-1:0] Y
);

  localparam int W  = WA + WB;
  localparam int CW = $clog2(WB + 1);

  state_t         r_state;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   r_mcand;
  logic [WB-1:0]  r_mplr;
  logic [CW-1:0]  r_cnt;
  logic           r_neg;

  logic [WA-1:0]  w_amag;
  logic [WB-1:0]  w_bmag;
  logic           w_aneg;
  logic           w_bneg;
  logic           w_last;
  logic [W-1:0]   w_x;
  logic [W-1:0]   w_y;
  logic           w_ci;
  logic [W-1:0]   w_sum;

  // Magnitudes fit in WA/WB unsigned bits, including the most
  // negative value (e.g. |-8| = 4'b1000).
  assign w_aneg = sgn & A[WA-1];
  assign w_bneg = sgn & B[WB-1];
  assign w_amag = w_aneg ? (~A + 1'b1) : A;
  assign w_bmag = w_bneg ? (~B + 1'b1) : B;

  assign w_last = (r_cnt == CW'(WB));

  // Iterations add the shifted multiplicand; the final RUN cycle
  // reuses the adder as ~acc + 1 to apply the sign.
  assign w_x  = (w_last && r_neg) ? ~r_acc : r_acc;
  assign w_y  = (!w_last && r_mplr[0]) ? r_mcand : '0;
  assign w_ci = w_last & r_neg;

  cla_add #(.W(W)) u_add (
    .i_a  (w_x),
    .i_b  (w_y),
    .i_ci (w_ci),
    .o_s  (w_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Y       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_acc   <= '0;
            r_mcand <= {{WB{1'b0}}, w_amag};
            r_mplr  <= w_bmag;
            r_cnt   <= '0;
            r_neg   <= w_aneg ^ w_bneg;
            busy    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (w_last) begin
            Y       <= w_sum;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_acc   <= w_sum;
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult at WA=WB=4.
// Arithmetic reference model plus directed literal checks.
module tb_shift_add_mult;

  localparam int WA = 4;
  localparam int WB = 4;
  localparam int W  = WA + WB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          sgn = 1'b0;
  logic [WA-1:0] A = '0;
  logic [WB-1:0] B = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  Y;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  shift_add_mult #(.WA(WA), .WB(WB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Y     (Y)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] prod(input logic s,
                                        input logic [WA-1:0] a,
                                        input logic [WB-1:0] b);
    int av;
    int bv;
    av = int'(a);
    bv = int'(b);
    if (s && a[WA-1]) av = av - (1 << WA);
    if (s && b[WB-1]) bv = bv - (1 << WB);
    return W'(av * bv);
  endfunction

  // Model: an accepted start yields the product WB+1 edges later.
  int           m_left = 0;
  logic [W-1:0] m_prod = '0;
  logic [W-1:0] m_Y = '0;
  logic         m_done = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_left <= 0;
      m_Y    <= '0;
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_Y    <= m_prod;
        m_done <= 1'b1;
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_left <= WB + 1;
        m_prod <= prod(sgn, A, B);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", int'(busy), int'(m_left > 0));
      check("model_done", int'(done), int'(m_done));
      check("model_Y", int'(Y), int'(m_Y));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; returns edges from accept to done (-1 on timeout).
  task automatic run_op(input logic s, input logic [WA-1:0] a,
                        input logic [WB-1:0] b, output int lat,
                        output logic [3:0] bmask);
    sgn = s; A = a; B = b; start = 1'b1;
    cyc();
    start = 1'b0;
    lat = -1;
    bmask = '0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k <= 4) bmask[k-1] = busy;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL op_timeout actual=none required=done");
    end
  endtask

  int lat;
  int n;
  int dones;
  logic [3:0] bm;
  logic [W-1:0] y1;

  initial begin
    check("pin_u15x15", int'(prod(1'b0, 4'd15, 4'd15)), 225);
    check("pin_s8x8", int'(prod(1'b1, 4'b1000, 4'b1000)), 8'h40);
    check("pin_s8x7", int'(prod(1'b1, 4'b1000, 4'b0111)), 8'hC8);
    check("pin_sm1xm1", int'(prod(1'b1, 4'hF, 4'hF)), 1);

    rst = 1'b0;
    cyc();
    cyc();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_Y", int'(Y), 0);
    rst = 1'b1;
    chk_en = 1'b1;
    cyc();

    run_op(1'b0, 4'd15, 4'd15, lat, bm);
    check("u15_lat", lat, WB + 1);
    check("u15_busy", int'(bm), 4'b1111);
    check("u15_busy_done", int'(busy), 0);
    check("u15_Y", int'(Y), 225);
    cyc();
    check("u15_pulse", int'(done), 0);
    check("u15_hold", int'(Y), 225);

    run_op(1'b1, 4'b1000, 4'b1000, lat, bm);
    check("s8x8_lat", lat, WB + 1);
    check("s8x8_Y", int'(Y), 8'h40);
    run_op(1'b1, 4'b1000, 4'b0111, lat, bm);
    check("s8x7_Y", int'(Y), 8'hC8);
    run_op(1'b1, 4'b0000, 4'b1111, lat, bm);
    check("zero_lat", lat, WB + 1);
    check("zero_Y", int'(Y), 0);

    // start during RUN with new operands must be ignored
    sgn = 1'b0; A = 4'd15; B = 4'd15; start = 1'b1;
    cyc();
    A = 4'd3; B = 4'd2;
    cyc();
    cyc();
    cyc();
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) begin
        dones++;
        y1 = Y;
      end
      cyc();
    end
    check("ign_dones", dones, 1);
    check("ign_Y", int'(y1), 225);

    // back-to-back: start held through DONE
    sgn = 1'b0; A = 4'd3; B = 4'd5; start = 1'b1;
    cyc();
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (done) begin
        lat = k;
        break;
      end
    end
    check("b2b_first_lat", lat, WB + 1);
    check("b2b_first_Y", int'(Y), 15);
    A = 4'd7; B = 4'd6;
    cyc();
    start = 1'b0;
    n = -1;
    for (int k = 2; k <= 20; k++) begin
      cyc();
      if (done) begin
        n = k;
        break;
      end
    end
    check("b2b_gap", n, WB + 2);
    check("b2b_second_Y", int'(Y), 42);

    // reset in the 2nd RUN cycle
    sgn = 1'b0; A = 4'd9; B = 4'd9; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_Y", int'(Y), 0);
    rst = 1'b1;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (done) dones++;
    end
    check("abort_nodone", dones, 0);
    run_op(1'b1, 4'b0111, 4'b1101, lat, bm);
    check("post_rst_lat", lat, WB + 1);
    check("post_rst_Y", int'(Y), 8'hEB);

    // randomized traffic checked every cycle by the model
    for (int k = 0; k < 2000; k++) begin
      start = ($urandom_range(0, 2) == 0);
      sgn   = 1'($urandom);
      A     = WA'($urandom);
      B     = WB'($urandom);
      rst   = ($urandom_range(0, 60) != 0);
      cyc();
    end
    rst = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 10; k++) cyc();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 SHALL have parameter WA, default 4, multiplicand width in bits (WA >= 2).
REQ-002 SHALL have parameter WB, default 4, multiplier width in bits (WB >= 2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port start  input  1  request to begin one multiplication.
REQ-006 SHALL have port sgn  input  1  operand mode: 0 = unsigned, 1 = two's-complement signed.
REQ-007 SHALL have port A  input  WA  multiplicand.
REQ-008 SHALL have port B  input  WB  multiplier.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking a valid new product.
REQ-011 SHALL have port Y  output  WA+WB  product register.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE, and SHALL then capture A, B and sgn into internal registers and enter RUN.
REQ-014 SHALL ignore start, A, B and sgn while in RUN; captured operands SHALL NOT change mid-operation.
REQ-015 SHALL, in signed mode, convert the captured operands to magnitudes and record sign = A[WA-1] XOR B[WB-1].
REQ-016 SHALL, in each RUN cycle, add the shifted multiplicand to the WA+WB-bit accumulator if the current multiplier LSB is 1, then shift the multiplier right by one.
REQ-017 SHALL perform exactly WB RUN iterations, counted by a $clog2(WB+1)-bit counter, then enter DONE.
REQ-018 SHALL, on entry to DONE, write Y = accumulator, negated if the signed mode sign is 1, and assert done for exactly that one cycle.
REQ-019 SHALL have fixed latency: start sampled at edge t gives done high and Y valid after edge t+WB+1 (5 cycles at the defaults); latency SHALL NOT depend on operand values.
REQ-020 SHALL assert busy in RUN only; busy SHALL be low in IDLE and DONE.
REQ-021 SHALL hold Y stable from DONE until the next DONE entry; Y SHALL NOT change while RUN is in progress.
REQ-022 SHALL return DONE to IDLE after one cycle when start is low; start high in DONE SHALL go directly to RUN, allowing back-to-back operations.
REQ-023 SHALL never overflow Y: the full product range, including (-2^(WA-1))*(-2^(WB-1)), fits in WA+WB signed bits.
REQ-024 SHALL produce Y = 0 when either operand is 0, including signed negative-zero cases (sign 1, magnitude 0 gives 0).

Reset
REQ-025 SHALL, when rst is low at a clock edge, force state to IDLE and clear Y, busy, done, the accumulator, the counter and the operand registers to 0.
REQ-026 SHALL abort an operation on reset in RUN without producing a done pulse; the first start after rst is released SHALL behave as from power-up.
REQ-027 SHALL give reset priority over start when both are active in the same cycle.

Structure
REQ-028 SHALL define the FSM state encoding (IDLE, RUN, DONE) as typedef/localparams in a shared package, mult_pkg.
REQ-029 SHALL place a parametrised carry-lookahead adder sub-module, cla_add (width WA+WB), in the accumulator path; the negation in REQ-018 SHALL reuse it with carry-in 1.
REQ-030 SHALL NOT contain display or binary-to-decimal logic; those remain external.

Verification (WA=4, WB=4)
REQ-031 SHALL verify unsigned A=15, B=15, start at edge t: busy high for edges t+1..t+4, done pulses once at t+5, Y=8'd225.
REQ-032 SHALL verify signed A=4'b1000, B=4'b1000: Y=8'h40 (64); signed A=4'b1000, B=4'b0111: Y=8'hC8 (-56).
REQ-033 SHALL verify that a start in RUN with different A/B leaves the result unchanged and produces no extra done pulse.
REQ-034 SHALL verify back-to-back: start held high through DONE gives a second operation whose done arrives WB+1 cycles after the first DONE cycle.
REQ-035 SHALL verify reset: rst low at the 2nd RUN cycle gives IDLE, Y=0, busy=0, done=0 next edge and no done pulse afterwards.
REQ-036 SHALL verify zero: signed A=0, B=4'b1111 gives Y=0 and done after 5 cycles.
